// File: rtl/mem_request_responder.sv
// Behavioural memory endpoint: round-robin over two write and two read request
// ports, one transaction at a time, against an internal word-addressed RAM.
module mem_request_responder #(
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       rd_req_valid_i,
  output logic [1:0]       rd_req_ready_o,
  input  logic [1:0][31:0] rd_req_addr_i,
  input  logic [1:0][7:0]  rd_req_len_i,
  output logic [1:0]       rd_data_valid_o,
  input  logic [1:0]       rd_data_ready_i,
  output logic [31:0]      rd_data_o,
  output logic             rd_data_last_o,
  input  logic [1:0]       wr_req_valid_i,
  output logic [1:0]       wr_req_ready_o,
  input  logic [1:0][31:0] wr_req_addr_i,
  input  logic [1:0][7:0]  wr_req_len_i,
  input  logic [1:0]       wr_data_valid_i,
  output logic [1:0]       wr_data_ready_o,
  input  logic [1:0][31:0] wr_data_i,
  input  logic [1:0][3:0]  wr_data_strb_i,
  input  logic [1:0]       wr_data_last_i,
  output logic [1:0]       wr_resp_valid_o,
  output logic             protocol_err_o
);

  // state      | meaning
  // S_IDLE     | arbitrating, granted source sees req_ready
  // S_RD_WAIT  | read accepted, burning LATENCY cycles
  // S_RD_BURST | presenting read beats to the owning port
  // S_WR_DATA  | accepting write beats from the owning port
  // S_WR_RESP  | one-cycle write-complete pulse
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_WAIT  = 3'd1;
  localparam logic [2:0] S_RD_BURST = 3'd2;
  localparam logic [2:0] S_WR_DATA  = 3'd3;
  localparam logic [2:0] S_WR_RESP  = 3'd4;

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'((LATENCY > 0) ? LATENCY - 1 : 0);

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [2:0]    state_q, state_d;
  logic [1:0]    rr_q, rr_d;
  logic          own_q, own_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          perr_q, perr_d;
  logic [31:0]   rdat_q;

  logic [3:0]    src_v;
  logic          grant_vld;
  logic [1:0]    grant_src;
  logic [AW-1:0] grant_addr;
  logic [7:0]    grant_len;
  logic          last_beat;
  logic          rd_hs;
  logic          wr_hs;
  logic          rd_load;
  logic [AW-1:0] rd_raddr;
  logic          unused_addr_bits;

  // Only the word-address field of a request address is meaningful.
  assign unused_addr_bits = ^{rd_req_addr_i, wr_req_addr_i};

  // Source numbering: 0 = wr0, 1 = wr1, 2 = rd0, 3 = rd1.
  assign src_v = {rd_req_valid_i, wr_req_valid_i};

  always_comb begin
    logic [1:0] idx;
    idx       = 2'd0;
    grant_vld = 1'b0;
    grant_src = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_q + 2'(i);
      if (src_v[idx]) begin
        grant_vld = 1'b1;
        grant_src = idx;
      end
    end
  end

  always_comb begin
    if (grant_src[1]) begin
      grant_addr = rd_req_addr_i[grant_src[0]][AW+1:2];
      grant_len  = rd_req_len_i[grant_src[0]];
    end else begin
      grant_addr = wr_req_addr_i[grant_src[0]][AW+1:2];
      grant_len  = wr_req_len_i[grant_src[0]];
    end
  end

  assign last_beat = (cnt_q == len_q);
  assign rd_hs     = (state_q == S_RD_BURST) && rd_data_ready_i[own_q];
  assign wr_hs     = (state_q == S_WR_DATA) && wr_data_valid_i[own_q];

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    own_d    = own_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    perr_d   = perr_q;
    rd_load  = 1'b0;
    rd_raddr = addr_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          rr_d   = grant_src + 2'd1;
          own_d  = grant_src[0];
          addr_d = grant_addr;
          len_d  = grant_len;
          cnt_d  = 8'd0;
          if (grant_src[1]) begin
            if (LATENCY == 0) begin
              state_d  = S_RD_BURST;
              rd_load  = 1'b1;
              rd_raddr = grant_addr;
            end else begin
              state_d = S_RD_WAIT;
              lat_d   = LAT_INIT;
            end
          end else begin
            state_d = S_WR_DATA;
          end
        end
      end
      S_RD_WAIT: begin
        if (lat_q == '0) begin
          state_d = S_RD_BURST;
          rd_load = 1'b1;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_RD_BURST: begin
        if (rd_hs) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            cnt_d    = cnt_q + 8'd1;
            addr_d   = addr_q + AW'(1);
            rd_load  = 1'b1;
            rd_raddr = addr_q + AW'(1);
          end
        end
      end
      S_WR_DATA: begin
        if (wr_hs) begin
          // The beat count decides the end of the burst; last is only audited.
          if (wr_data_last_i[own_q] != last_beat) begin
            perr_d = 1'b1;
          end
          if (last_beat) begin
            state_d = S_WR_RESP;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = addr_q + AW'(1);
          end
        end
      end
      S_WR_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rr_q    <= 2'd0;
      own_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      lat_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      perr_q  <= perr_d;
    end
  end

  // Read data is registered so a stalled beat holds without re-reading the RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdat_q <= 32'd0;
    end else if (rd_load) begin
      rdat_q <= mem_q[rd_raddr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_data_strb_i[own_q][b]) begin
          mem_q[addr_q][8*b +: 8] <= wr_data_i[own_q][8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_req_ready_o  = 2'b00;
    wr_req_ready_o  = 2'b00;
    rd_data_valid_o = 2'b00;
    wr_data_ready_o = 2'b00;
    wr_resp_valid_o = 2'b00;
    for (int p = 0; p < 2; p++) begin
      if (rst_ni && (state_q == S_IDLE) && grant_vld) begin
        rd_req_ready_o[p] = (grant_src == {1'b1, 1'(p)});
        wr_req_ready_o[p] = (grant_src == {1'b0, 1'(p)});
      end
      if (rst_ni && (own_q == 1'(p))) begin
        rd_data_valid_o[p] = (state_q == S_RD_BURST);
        wr_data_ready_o[p] = (state_q == S_WR_DATA);
        wr_resp_valid_o[p] = (state_q == S_WR_RESP);
      end
    end
  end

  assign rd_data_o      = rdat_q;
  assign rd_data_last_o = rst_ni && (state_q == S_RD_BURST) && last_beat;
  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_mem_request_responder.sv
// Directed plus randomized bench for mem_request_responder against a plain
// word-array memory model with explicit beat timing expectations.
module tb_mem_request_responder;
  localparam int D   = 16384;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       rd_req_valid, rd_req_ready;
  logic [1:0][31:0] rd_req_addr;
  logic [1:0][7:0]  rd_req_len;
  logic [1:0]       rd_data_valid, rd_data_ready;
  logic [31:0]      rd_data;
  logic             rd_data_last;
  logic [1:0]       wr_req_valid, wr_req_ready;
  logic [1:0][31:0] wr_req_addr;
  logic [1:0][7:0]  wr_req_len;
  logic [1:0]       wr_data_valid, wr_data_ready;
  logic [1:0][31:0] wr_data;
  logic [1:0][3:0]  wr_data_strb;
  logic [1:0]       wr_data_last;
  logic [1:0]       wr_resp_valid;
  logic             protocol_err;

  mem_request_responder #(.DEPTH_WORDS(D), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_req_valid_i(rd_req_valid), .rd_req_ready_o(rd_req_ready),
    .rd_req_addr_i(rd_req_addr), .rd_req_len_i(rd_req_len),
    .rd_data_valid_o(rd_data_valid), .rd_data_ready_i(rd_data_ready),
    .rd_data_o(rd_data), .rd_data_last_o(rd_data_last),
    .wr_req_valid_i(wr_req_valid), .wr_req_ready_o(wr_req_ready),
    .wr_req_addr_i(wr_req_addr), .wr_req_len_i(wr_req_len),
    .wr_data_valid_i(wr_data_valid), .wr_data_ready_o(wr_data_ready),
    .wr_data_i(wr_data), .wr_data_strb_i(wr_data_strb), .wr_data_last_i(wr_data_last),
    .wr_resp_valid_o(wr_resp_valid), .protocol_err_o(protocol_err)
  );

  logic [31:0] model [D];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        exp_perr = 1'b0;
  logic [31:0] first_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'(D - 1));
  endfunction

  task automatic chk_zero(input string tag);
    chk(tag, 32'({rd_req_ready, wr_req_ready, wr_data_ready, rd_data_valid,
                  wr_resp_valid, rd_data_last, protocol_err}), 32'd0);
    chk({tag, "_data"}, rd_data, 32'd0);
  endtask

  task automatic do_read(input int p, input logic [31:0] a, input int len,
                         input int stall_beat, input int stall_n);
    int n;
    int w;
    w = widx(a);
    rd_data_ready[p] = 1'b1;
    rd_req_valid[p]  = 1'b1;
    rd_req_addr[p]   = a;
    rd_req_len[p]    = 8'(len);
    #1;
    n = 0;
    while (!rd_req_ready[p] && n < 50) begin
      tick(); #1; n++;
    end
    chk("rd_req_ready", 32'({rd_req_ready, wr_req_ready}), 32'(4'b0100 << p));
    tick();
    rd_req_valid[p] = 1'b0;
    repeat (LAT) begin
      #1;
      chk("rd_wait_valid", 32'(rd_data_valid), 32'd0);
      tick();
    end
    for (int k = 0; k <= len; k++) begin
      #1;
      if (k == stall_beat) begin
        rd_data_ready[p] = 1'b0;
        repeat (stall_n) begin
          chk("rd_stall_valid", 32'(rd_data_valid), 32'(2'b01 << p));
          chk("rd_stall_data", rd_data, model[(w + k) % D]);
          chk("rd_stall_last", 32'(rd_data_last), 32'(k == len));
          tick(); #1;
        end
        rd_data_ready[p] = 1'b1;
      end
      chk("rd_valid", 32'(rd_data_valid), 32'(2'b01 << p));
      chk("rd_data", rd_data, model[(w + k) % D]);
      chk("rd_last", 32'(rd_data_last), 32'(k == len));
      if (k == 0) first_beat = rd_data;
      tick();
    end
    #1;
    chk("rd_done", 32'(rd_data_valid), 32'd0);
  endtask

  task automatic do_write(input int p, input logic [31:0] a, input int len,
                          input logic [31:0] d0, input logic [3:0] s0, input int bad_beat);
    int n;
    int w;
    logic [31:0] d;
    logic [3:0] s;
    logic lst;
    w = widx(a);
    wr_req_valid[p] = 1'b1;
    wr_req_addr[p]  = a;
    wr_req_len[p]   = 8'(len);
    #1;
    n = 0;
    while (!wr_req_ready[p] && n < 50) begin
      tick(); #1; n++;
    end
    chk("wr_req_ready", 32'({rd_req_ready, wr_req_ready}), 32'(4'b0001 << p));
    tick();
    wr_req_valid[p] = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_data_valid[p] = 1'b0;
        #1;
        chk("wr_rdy_gap", 32'(wr_data_ready), 32'(2'b01 << p));
        tick();
      end
      d   = (k == 0) ? d0 : $urandom;
      s   = (k == 0) ? s0 : 4'($urandom);
      lst = (k == len) || (k == bad_beat);
      wr_data_valid[p] = 1'b1;
      wr_data[p]       = d;
      wr_data_strb[p]  = s;
      wr_data_last[p]  = lst;
      #1;
      chk("wr_rdy", 32'(wr_data_ready), 32'(2'b01 << p));
      for (int b = 0; b < 4; b++)
        if (s[b]) model[(w + k) % D][8*b +: 8] = d[8*b +: 8];
      if (lst != (k == len)) exp_perr = 1'b1;
      tick();
    end
    wr_data_valid[p] = 1'b0;
    wr_data_last[p]  = 1'b0;
    #1;
    chk("wr_resp", 32'(wr_resp_valid), 32'(2'b01 << p));
    chk("perr", 32'(protocol_err), 32'(exp_perr));
    tick(); #1;
    chk("wr_resp_once", 32'(wr_resp_valid), 32'd0);
  endtask

  initial begin
    int got;
    int exp_src;
    int n;
    int w;
    logic [31:0] v;
    logic [31:0] a;

    // All four sources requesting continuously from reset.
    rst_n = 1'b0;
    rd_req_valid = 2'b11; wr_req_valid = 2'b11;
    rd_req_addr = '0; wr_req_addr = '0; rd_req_len = '0; wr_req_len = '0;
    rd_data_ready = 2'b11; wr_data_valid = 2'b11; wr_data = '0;
    wr_data_strb = '0; wr_data_last = 2'b11;
    repeat (3) tick();
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    got = 0; exp_src = 0; n = 0;
    while (got < 8 && n < 300) begin
      #1;
      if ({rd_req_ready, wr_req_ready} != 4'b0000) begin
        chk("arb_grant", 32'({rd_req_ready, wr_req_ready}), 32'(4'b0001 << exp_src));
        exp_src = (exp_src + 1) % 4;
        got++;
      end
      tick();
      n++;
    end
    rd_req_valid = 2'b00; wr_req_valid = 2'b00;
    chk("arb_count", 32'(got), 32'd8);
    repeat (12) tick();
    wr_data_valid = 2'b00; wr_data_last = 2'b00;
    chk("arb_perr", 32'(protocol_err), 32'd0);

    for (int i = 0; i < D; i++) begin
      v = $urandom;
      dut.mem_q[i] = v;
      model[i] = v;
    end
    for (int i = 0; i < 4; i++) begin
      v = 32'h1111_1111 * 32'(i + 1);
      dut.mem_q[16'h40 + i] = v;
      model[16'h40 + i] = v;
    end
    dut.mem_q[16'h80] = 32'd0;
    model[16'h80] = 32'd0;
    tick();

    do_read(0, 32'h100, 3, -1, 0);
    chk("rd0_first", first_beat, 32'h1111_1111);
    do_write(1, 32'h200, 0, 32'hAABB_CCDD, 4'b0101, -1);
    do_read(1, 32'h200, 0, -1, 0);
    chk("strb_merge", first_beat, 32'h00BB_00DD);
    do_read(0, 32'h100, 2, 1, 3);
    do_read(0, 32'(4 * (D - 1)), 1, -1, 0);
    do_write(0, 32'h300, 1, $urandom, 4'hF, 0);
    do_read(1, 32'h300, 1, -1, 0);

    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 3) == 0) ? (D - 8 + int'($urandom_range(0, 7))) : int'($urandom_range(0, 63));
      a = ($urandom & 32'hFFFC_0000) | (32'(w) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        do_read(int'($urandom_range(0, 1)), a, int'($urandom_range(0, 6)),
                int'($urandom_range(0, 8)), int'($urandom_range(1, 3)));
      else
        do_write(int'($urandom_range(0, 1)), a, int'($urandom_range(0, 6)),
                 $urandom, 4'($urandom), -1);
    end
    chk("perr_sticky", 32'(protocol_err), 32'(exp_perr));

    // Reset in the middle of a read burst.
    rd_data_ready[0] = 1'b1;
    rd_req_valid[0] = 1'b1; rd_req_addr[0] = 32'h400; rd_req_len[0] = 8'd7;
    #1;
    n = 0;
    while (!rd_req_ready[0] && n < 50) begin tick(); #1; n++; end
    chk("mid_rd_acc", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid[0] = 1'b0;
    repeat (LAT + 1) tick();
    #1;
    chk("mid_rd_active", 32'(rd_data_valid), 32'd1);
    rst_n = 1'b0;
    tick(); #1;
    chk_zero("mid_rd_reset");
    rst_n = 1'b1;
    exp_perr = 1'b0;
    tick();
    do_read(1, 32'h404, 1, -1, 0);

    // Reset in the middle of a write burst: beats already taken must stick.
    w = widx(32'h500);
    wr_req_valid[0] = 1'b1; wr_req_addr[0] = 32'h500; wr_req_len[0] = 8'd3;
    #1;
    n = 0;
    while (!wr_req_ready[0] && n < 50) begin tick(); #1; n++; end
    chk("mid_wr_acc", 32'(wr_req_ready), 32'd1);
    tick();
    wr_req_valid[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      v = $urandom;
      wr_data_valid[0] = 1'b1; wr_data[0] = v; wr_data_strb[0] = 4'hF; wr_data_last[0] = 1'b0;
      model[w + k] = v;
      tick();
    end
    wr_data_valid[0] = 1'b0;
    rst_n = 1'b0;
    tick(); #1;
    chk_zero("mid_wr_reset");
    rst_n = 1'b1;
    tick(); #1;
    chk("mid_wr_noresp", 32'(wr_resp_valid), 32'd0);
    do_read(0, 32'h500, 3, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_request_responder.md
# mem_request_responder

Memory-side responder for the two read and two write request/data channel pairs the load/store path drives (index 0 = dcache line traffic, index 1 = uncached/MMIO). It arbitrates the four request sources round-robin, serves one transaction at a time from an internal word-addressed RAM, streams read bursts back with `last` and accepts write bursts with byte strobes. It serves as the behavioural memory endpoint in unit and core-level benches, and as the template for the later AXI-facing bridge.

## Interface
- `DEPTH_WORDS`, 16384: RAM size in 32-bit words; power of two.
- `LATENCY`, 2: idle cycles between read-request acceptance and the first read beat; must be ≥0.
- `clk`  in  1  sole clock; all state on the rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `rd_req_valid[2]` in 1, `rd_req_ready[2]` out 1, `rd_req_addr[2]` in 32, `rd_req_len[2]` in 8: read request; `len` = beats−1.
- `rd_data_valid[2]` out 1, `rd_data_ready[2]` in 1, `rd_data` out 32, `rd_data_last` out 1: read beats; `rd_data`/`last` are shared and qualified by the asserted `valid`.
- `wr_req_valid[2]` in 1, `wr_req_ready[2]` out 1, `wr_req_addr[2]` in 32, `wr_req_len[2]` in 8: write request; `len` = beats−1.
- `wr_data_valid[2]` in 1, `wr_data_ready[2]` out 1, `wr_data[2]` in 32, `wr_data_strb[2]` in 4, `wr_data_last[2]` in 1: write beats.
- `wr_resp_valid[2]`  out  1  one-cycle write-complete pulse; no ready.
- `protocol_err`  out  1  sticky; set when `wr_data_last` disagrees with the beat count.

## Operation
- Sources are numbered 0 = wr0, 1 = wr1, 2 = rd0, 3 = rd1. The round-robin pointer `rr` (2 bits) names the highest-priority source.
- In IDLE, grant goes to the first valid source scanning `rr`, `rr`+1, … mod 4. Only the granted source's `*_req_ready` is high, combinationally, in that IDLE cycle. On handshake: latch addr and len, set `rr` ← granted+1 mod 4, clear the beat counter.
- Word address = `addr[log2(DEPTH_WORDS)+1:2]`; `addr[1:0]` is ignored. The address increments by one word per beat and wraps modulo `DEPTH_WORDS`.
- States are IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_RESP.
  - IDLE → RD_WAIT on a read grant. If `LATENCY`=0, go straight to RD_BURST.
  - RD_WAIT: count `LATENCY` cycles, then go to RD_BURST.
  - RD_BURST: `rd_data_valid` is high for the owning port only, with `rd_data` = RAM[word]. `rd_data_last` = (count == len). While `ready` is low, data, last and valid hold. After the handshake on the last beat, go to IDLE.
  - IDLE → WR_DATA on a write grant. `wr_data_ready` is high for the owning port only.
  - WR_DATA: each handshake writes the bytes whose `strb` bit is set. On the beat where count == len, go to WR_RESP. The beat count is authoritative. If `wr_data_last` ≠ (count == len) on any beat, set `protocol_err`.
  - WR_RESP: pulse `wr_resp_valid` for the owning port for 1 cycle, then IDLE.
- The non-owning port never sees valid/ready high. Its request waits, with `*_req_ready` low.
- RAM is not reset or initialised. Bench preload uses hierarchical access.
- Reset: state IDLE, `rr`=0, counters 0. Every `*_ready`, `*_valid`, `rd_data_last` and `protocol_err` is 0, and `rd_data` is 0. Reset mid-burst drops the transaction with no response; RAM keeps any beats already written.

## Timing
- Read accepted at cycle T: the first beat is valid at T+1+`LATENCY`. With `ready` held high, beat k is at T+1+`LATENCY`+k. Total = len+1 beats.
- Write accepted at T: `wr_data_ready` goes high from T+1. The last beat is handshaken at T+1+len at full rate. `wr_resp_valid` is high in the cycle after the last beat.
- The earliest next grant is the cycle after the last read beat, or the cycle after `wr_resp_valid`.
- A read issued after a `wr_resp_valid` to the same word returns the new data.
- A request whose valid rises while another transaction is in progress is granted in the next IDLE cycle, per `rr`.

## Test plan
- Preload RAM[0x40..0x43] = 0x11111111..0x44444444. rd0 requests addr 0x100, len 3, `LATENCY`=2, ready=1 → accept at T. Beats at T+3..T+6 carry 0x11111111..0x44444444 with `last` only at T+6. `rd_data_valid[1]` stays 0 throughout.
- wr1 to addr 0x200, len 0, data 0xAABBCCDD, strb 0b0101 over old 0x00000000 → `wr_resp_valid[1]` pulses once. A following rd1 of 0x200 returns 0x00BB00DD.
- All four request valids held high from reset → grants in order wr0, wr1, rd0, rd1, wr0 …; no source is granted twice before the others.
- rd0 len 2, with `rd_data_ready` low for 3 cycles on beat 1 → beat 1's data and `last`=0 are held stable; the sequence completes intact.
- wr0 len 1 with `wr_data_last`=1 on beat 0 → `protocol_err` goes to 1 and stays at 1. Two beats are still written, then `wr_resp_valid[0]` pulses.
- rd0 at addr 4·(`DEPTH_WORDS`−1), len 1 → the second beat returns RAM[0]. Separately, assert reset in mid-burst → all outputs are 0 the next cycle and the FSM is IDLE.
